// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand fetch, issue and writeback around a 1-cycle registered ALU.
// Decodes a 16-bit instruction, reads an 8x16 register file (r0 hardwired to 0),
// drives the ALU one-hot op and operands, and writes the ALU result back in WB.
// A writeback bypass lets an instruction accepted in WB see the result being written.
module alu_issue_stage #(
   parameter int DATA_WIDTH      = 16,
   parameter int IMM_SIGN_EXTEND = 0
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic [15:0]           iInstr,
   input  logic                  iInstrValid,
   output logic                  oInstrReady,
   output logic [DATA_WIDTH-1:0] oOperandA,
   output logic [DATA_WIDTH-1:0] oOperandB,
   output logic [4:0]            oOperation,
   input  logic [DATA_WIDTH-1:0] iAluResult,
   output logic                  oWbValid,
   output logic [2:0]            oWbAddr,
   output logic [DATA_WIDTH-1:0] oWbData,
   input  logic [2:0]            iDbgAddr,
   output logic [DATA_WIDTH-1:0] oDbgData
);

   // FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_WB   = 2'd2;

   // Instruction opcodes
   localparam logic [2:0] OPC_NOP = 3'd0;
   localparam logic [2:0] OPC_ADD = 3'd1;
   localparam logic [2:0] OPC_XOR = 3'd2;
   localparam logic [2:0] OPC_OR  = 3'd3;
   localparam logic [2:0] OPC_NOT = 3'd4;
   localparam logic [2:0] OPC_AND = 3'd5;
   localparam logic [2:0] OPC_MOV = 3'd6;
   localparam logic [2:0] OPC_LDI = 3'd7;

   // ALU one-hot operation codes; NONE makes the ALU pass operand B
   localparam logic [4:0] ALU_NONE = 5'b00000;
   localparam logic [4:0] ALU_ADD  = 5'b00001;
   localparam logic [4:0] ALU_XOR  = 5'b00010;
   localparam logic [4:0] ALU_OR   = 5'b00100;
   localparam logic [4:0] ALU_NOT  = 5'b01000;
   localparam logic [4:0] ALU_AND  = 5'b10000;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [DATA_WIDTH-1:0] regs [8];
   logic [2:0]            rd_p1;

   logic [2:0]            opcode;
   logic [2:0]            rd;
   logic [2:0]            rs_a;
   logic [2:0]            rs_b;
   logic [6:0]            imm7;
   logic                  imm_fill;
   logic [DATA_WIDTH-1:0] imm_ext;
   logic                  accept;
   logic                  is_nop;
   logic                  in_wb;
   logic                  wb_write;
   logic                  hit_a;
   logic                  hit_b;
   logic [DATA_WIDTH-1:0] val_a;
   logic [DATA_WIDTH-1:0] val_b;
   logic [DATA_WIDTH-1:0] a_nxt;
   logic [DATA_WIDTH-1:0] b_nxt;
   logic [4:0]            op_nxt;

   assign opcode = iInstr[15:13];
   assign rd     = iInstr[12:10];
   assign rs_a   = iInstr[9:7];
   assign rs_b   = iInstr[6:4];
   assign imm7   = iInstr[6:0];

   assign imm_fill = (IMM_SIGN_EXTEND != 0) & imm7[6];
   assign imm_ext  = {{(DATA_WIDTH-7){imm_fill}}, imm7};

   // Ready is forced low while reset is held so nothing is accepted mid-reset
   assign oInstrReady = iReset & (state != ST_EXEC);
   assign accept      = iInstrValid & oInstrReady;
   assign is_nop      = (opcode == OPC_NOP);
   assign in_wb       = (state == ST_WB);
   assign wb_write    = in_wb & (rd_p1 != 3'd0);

   // The register being written this cycle is stale in the array; forward the ALU result
   assign hit_a = wb_write & (rs_a == rd_p1);
   assign hit_b = wb_write & (rs_b == rd_p1);
   assign val_a = hit_a ? iAluResult : regs[rs_a];
   assign val_b = hit_b ? iAluResult : regs[rs_b];

   assign oWbValid = in_wb;
   assign oWbAddr  = rd_p1;
   assign oWbData  = iAluResult;
   assign oDbgData = (iDbgAddr == 3'd0) ? '0 : regs[iDbgAddr];

   // Decode: choose ALU op and operand values for the incoming instruction
   always_comb begin
      op_nxt = ALU_NONE;
      a_nxt  = '0;
      b_nxt  = '0;
      case (opcode)
         OPC_ADD: begin op_nxt = ALU_ADD; a_nxt = val_a; b_nxt = val_b; end
         OPC_XOR: begin op_nxt = ALU_XOR; a_nxt = val_a; b_nxt = val_b; end
         OPC_OR:  begin op_nxt = ALU_OR;  a_nxt = val_a; b_nxt = val_b; end
         OPC_NOT: begin op_nxt = ALU_NOT; a_nxt = val_a; end
         OPC_AND: begin op_nxt = ALU_AND; a_nxt = val_a; b_nxt = val_b; end
         OPC_MOV: b_nxt = val_b;
         OPC_LDI: b_nxt = imm_ext;
         default: ;
      endcase
   end

   // Next-state: non-NOP accepts go to EXEC, EXEC always proceeds to WB
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept && !is_nop) state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = ST_WB;
         ST_WB:   state_nxt = (accept && !is_nop) ? ST_EXEC : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Issue stage boundary: operands, op and destination load only on accept
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         oOperandA  <= '0;
         oOperandB  <= '0;
         oOperation <= ALU_NONE;
         rd_p1      <= 3'd0;
      end else if (accept) begin
         oOperandA  <= a_nxt;
         oOperandB  <= b_nxt;
         oOperation <= op_nxt;
         rd_p1      <= rd;
      end
   end

   // Writeback stage boundary: commit the ALU result at the edge closing WB; r0 never written
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (wb_write) begin
         regs[rd_p1] <= iAluResult;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: two instances (zero- and sign-extending LDI) share stimulus.
// An architectural reference model predicts handshakes, operands, writebacks and registers.
module tb_alu_issue_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] instr;
   logic        vld;
   logic [2:0]  dbg_addr;

   logic        rdy0, rdy1, wbv0, wbv1;
   logic [15:0] a0, a1, b0, b1, alu0, alu1, wbd0, wbd1, dbg0, dbg1;
   logic [4:0]  op0, op1;
   logic [2:0]  wba0, wba1;

   alu_issue_stage #(.DATA_WIDTH(16), .IMM_SIGN_EXTEND(0)) dut0 (
      .iClock(clk), .iReset(rst_n), .iInstr(instr), .iInstrValid(vld),
      .oInstrReady(rdy0), .oOperandA(a0), .oOperandB(b0), .oOperation(op0),
      .iAluResult(alu0), .oWbValid(wbv0), .oWbAddr(wba0), .oWbData(wbd0),
      .iDbgAddr(dbg_addr), .oDbgData(dbg0));

   alu_issue_stage #(.DATA_WIDTH(16), .IMM_SIGN_EXTEND(1)) dut1 (
      .iClock(clk), .iReset(rst_n), .iInstr(instr), .iInstrValid(vld),
      .oInstrReady(rdy1), .oOperandA(a1), .oOperandB(b1), .oOperation(op1),
      .iAluResult(alu1), .oWbValid(wbv1), .oWbAddr(wba1), .oWbData(wbd1),
      .iDbgAddr(dbg_addr), .oDbgData(dbg1));

   // Downstream ALU: one registered cycle of latency
   function automatic logic [15:0] alu_f(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         5'b00001: return a + b;
         5'b00010: return a ^ b;
         5'b00100: return a | b;
         5'b01000: return ~a;
         5'b10000: return a & b;
         default:  return b;
      endcase
   endfunction

   always @(posedge clk) begin
      alu0 <= alu_f(op0, a0, b0);
      alu1 <= alu_f(op1, a1, b1);
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model: m_arch is what the register file shows, m_fut includes the in-flight result
   logic [15:0] m_arch [2][8];
   logic [15:0] m_fut  [2][8];
   int          cyc;
   int          issue_cyc;
   logic [2:0]  issue_rd;
   logic [15:0] issue_res [2];
   logic [4:0]  e_op;
   logic [15:0] e_a [2];
   logic [15:0] e_b [2];
   logic        e_use_a, e_use_b;
   logic        exp_rdy, exp_wbv;
   logic        acc_now;
   int          acc_cyc;

   task automatic reset_model();
      for (int i = 0; i < 2; i++) begin
         for (int r = 0; r < 8; r++) begin
            m_arch[i][r] = 16'h0;
            m_fut[i][r]  = 16'h0;
         end
         e_a[i] = 16'h0;
         e_b[i] = 16'h0;
         issue_res[i] = 16'h0;
      end
      issue_cyc = -100;
      issue_rd  = 3'd0;
      e_op      = 5'b00000;
      e_use_a   = 1'b1;
      e_use_b   = 1'b1;
      acc_now   = 1'b0;
   endtask

   task automatic check_inst(input int i, input logic rdy, input logic [15:0] a, input logic [15:0] b,
                             input logic [4:0] op, input logic wbv, input logic [2:0] wba,
                             input logic [15:0] wbd, input logic [15:0] dbg);
      chk($sformatf("ready%0d@%0d", i, cyc), rdy, exp_rdy);
      chk($sformatf("wbvalid%0d@%0d", i, cyc), wbv, exp_wbv);
      if (exp_wbv) begin
         chk($sformatf("wbaddr%0d@%0d", i, cyc), wba, issue_rd);
         chk($sformatf("wbdata%0d@%0d", i, cyc), wbd, issue_res[i]);
      end
      chk($sformatf("op%0d@%0d", i, cyc), op, e_op);
      if (e_use_a) chk($sformatf("opA%0d@%0d", i, cyc), a, e_a[i]);
      if (e_use_b) chk($sformatf("opB%0d@%0d", i, cyc), b, e_b[i]);
      chk($sformatf("dbg%0d_r%0d@%0d", i, dbg_addr, cyc), dbg, m_arch[i][dbg_addr]);
   endtask

   // Called mid-cycle: check outputs, then advance the model across the coming edge
   task automatic cycle_check();
      logic [2:0]  opc, rd, ra, rb;
      logic [6:0]  imm;
      logic [15:0] va, vb, immx, res;
      exp_rdy = (cyc != issue_cyc + 1);
      exp_wbv = (cyc == issue_cyc + 2);
      check_inst(0, rdy0, a0, b0, op0, wbv0, wba0, wbd0, dbg0);
      check_inst(1, rdy1, a1, b1, op1, wbv1, wba1, wbd1, dbg1);
      if (exp_wbv && issue_rd != 3'd0) begin
         m_arch[0][issue_rd] = issue_res[0];
         m_arch[1][issue_rd] = issue_res[1];
      end
      acc_now = vld && exp_rdy;
      if (acc_now) begin
         acc_cyc = cyc;
         opc = instr[15:13]; rd = instr[12:10]; ra = instr[9:7]; rb = instr[6:4]; imm = instr[6:0];
         for (int i = 0; i < 2; i++) begin
            va   = m_fut[i][ra];
            vb   = m_fut[i][rb];
            immx = (i == 1 && imm[6]) ? {9'h1FF, imm} : {9'h000, imm};
            e_a[i] = va; e_b[i] = vb; e_use_a = 1'b1; e_use_b = 1'b1;
            case (opc)
               3'd1: begin res = va + vb; e_op = 5'b00001; end
               3'd2: begin res = va ^ vb; e_op = 5'b00010; end
               3'd3: begin res = va | vb; e_op = 5'b00100; end
               3'd4: begin res = ~va;     e_op = 5'b01000; e_use_b = 1'b0; end
               3'd5: begin res = va & vb; e_op = 5'b10000; end
               3'd6: begin res = vb;      e_op = 5'b00000; e_use_a = 1'b0; end
               3'd7: begin res = immx;    e_op = 5'b00000; e_use_a = 1'b0; e_b[i] = immx; end
               default: begin res = 16'h0; e_op = 5'b00000; e_a[i] = 16'h0; e_b[i] = 16'h0; end
            endcase
            if (opc != 3'd0) begin
               issue_res[i] = res;
               if (rd != 3'd0) m_fut[i][rd] = res;
            end
         end
         if (opc != 3'd0) begin
            issue_cyc = cyc;
            issue_rd  = rd;
         end
      end
   endtask

   task automatic step();
      dbg_addr = 3'($urandom_range(0, 7));
      @(negedge clk);
      cycle_check();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic issue(input logic [15:0] ins, output int acc);
      instr = ins;
      vld   = 1'b1;
      acc   = -1;
      for (int n = 0; n < 8 && acc < 0; n++) begin
         step();
         if (acc_now) acc = acc_cyc;
      end
      if (acc < 0) chk("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      vld   = 1'b0;
      instr = 16'($urandom);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic dbg_chk(input string tag, input logic [2:0] addr, input logic [15:0] e0, input logic [15:0] e1);
      dbg_addr = addr;
      #1;
      chk({tag, "_z"}, dbg0, e0);
      chk({tag, "_s"}, dbg1, e1);
   endtask

   task automatic rand_run(input int n);
      for (int k = 0; k < n; k++) begin
         if (!vld || acc_now) begin
            instr = 16'($urandom);
            vld   = ($urandom_range(0, 3) != 0);
         end
         step();
      end
      vld = 1'b0;
   endtask

   function automatic logic [15:0] enc_r(input logic [2:0] opc, input logic [2:0] rd,
                                         input logic [2:0] ra, input logic [2:0] rb);
      return {opc, rd, ra, rb, 4'b0000};
   endfunction

   function automatic logic [15:0] enc_i(input logic [2:0] rd, input logic [6:0] imm);
      return {3'b111, rd, 3'b000, imm};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c1, c2, c3;
      rst_n = 1'b0; vld = 1'b0; instr = 16'h0; dbg_addr = 3'd0; cyc = 0;
      reset_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", rdy0, 1'b0);
      chk("rst_ready1", rdy1, 1'b0);
      chk("rst_op", op0, 5'b00000);
      chk("rst_opA", a0, 16'h0);
      chk("rst_opB", b0, 16'h0);
      chk("rst_wbvalid", wbv0, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("rel_ready", rdy0, 1'b1);

      // Back-to-back LDI, LDI, ADD with valid held
      issue(enc_i(3'd1, 7'd5), c1);
      issue(enc_i(3'd2, 7'd3), c2);
      issue(enc_r(3'd1, 3'd3, 3'd1, 3'd2), c3);
      chk("acc_first", c1, 0);
      chk("acc_gap1", c2 - c1, 2);
      chk("acc_gap2", c3 - c2, 2);
      chk("add_exec_op0", op0, 5'b00001);
      chk("add_exec_op1", op1, 5'b00001);
      idle(3);
      dbg_chk("r3_add", 3'd3, 16'h0008, 16'h0008);

      // Bypass: XOR reads r1 while r1 is being written
      issue(enc_i(3'd1, 7'h7F), c1);
      issue(enc_r(3'd2, 3'd4, 3'd1, 3'd1), c2);
      chk("byp_A_z", a0, 16'h007F);
      chk("byp_B_z", b0, 16'h007F);
      chk("byp_A_s", a1, 16'hFFFF);
      chk("byp_B_s", b1, 16'hFFFF);
      idle(3);
      dbg_chk("r4_xor", 3'd4, 16'h0000, 16'h0000);

      // Writes to r0 pulse writeback but are dropped
      issue(enc_i(3'd5, 7'h33), c1);
      issue(enc_i(3'd0, 7'd9), c2);
      vld = 1'b0;
      step();
      chk("r0_wbvalid", wbv0, 1'b1);
      chk("r0_wbaddr", wba0, 3'd0);
      idle(2);
      dbg_chk("r0_read", 3'd0, 16'h0000, 16'h0000);
      issue(enc_r(3'd6, 3'd5, 3'd0, 3'd0), c1);
      idle(3);
      dbg_chk("r5_mov", 3'd5, 16'h0000, 16'h0000);

      // LDI 0x40 extension and NOT
      issue(enc_i(3'd6, 7'h40), c1);
      issue(enc_r(3'd4, 3'd7, 3'd6, 3'd0), c2);
      chk("not_exec_op", op1, 5'b01000);
      idle(3);
      dbg_chk("r6_ldi", 3'd6, 16'h0040, 16'hFFC0);
      dbg_chk("r7_not", 3'd7, 16'hFFBF, 16'h003F);

      // Valid held through EXEC must not double-accept; NOP in IDLE stays idle
      idle(2);
      issue(enc_i(3'd2, 7'd1), c1);
      issue(enc_i(3'd2, 7'd2), c2);
      chk("stall_gap", c2 - c1, 2);
      idle(3);
      issue(16'h0000, c1);
      chk("nop_op", op0, 5'b00000);
      chk("nop_ready", rdy0, 1'b1);
      chk("nop_wbvalid", wbv0, 1'b0);
      idle(2);
      dbg_chk("r2_stall", 3'd2, 16'h0002, 16'h0002);

      // Async reset during EXEC of ADD r3
      issue(enc_i(3'd3, 7'h11), c1);
      idle(3);
      dbg_chk("r3_pre", 3'd3, 16'h0011, 16'h0011);
      issue(enc_r(3'd1, 3'd3, 3'd3, 3'd3), c1);
      vld = 1'b0;
      dbg_addr = 3'd3;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_op", op0, 5'b00000);
      chk("arst_opA", a0, 16'h0);
      chk("arst_opB", b1, 16'h0);
      chk("arst_ready", rdy0, 1'b0);
      chk("arst_wbvalid", wbv0, 1'b0);
      chk("arst_r3", dbg0, 16'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      reset_model();
      idle(4);
      dbg_chk("r3_post", 3'd3, 16'h0000, 16'h0000);

      // Randomized traffic against the model
      rand_run(400);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
